i2c_cfg_seq: RTL and testbench
==============================

I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, is the 7-bit I2C device address driven on every transaction.
REQ-002 Parameter NUM_REGS, default 10, is the number of table entries to write (0-255).
REQ-003 Parameter START_TIMEOUT, default 4096, is the number of clk_50 cycles to wait for the master to go busy.
REQ-004 Parameter DONE_TIMEOUT, default 65535, is the number of clk_50 cycles to wait for the master to go idle.
REQ-005 Parameter GAP_CYCLES, default 256, is the number of idle clk_50 cycles between transactions.
REQ-006 clk_50  in  1  system clock; one clock; all state on its rising edge.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle pulse that begins a configuration run.
REQ-009 busy  out  1  high while a run is in progress.
REQ-010 done  out  1  high after a run completes with no failure; held until the next accepted start.
REQ-011 fail  out  1  high after a run aborts; held until the next accepted start.
REQ-012 tbl_addr  out  8  table ROM address; on failure it holds the index of the failing entry.
REQ-013 tbl_data  in  16  ROM word {sub_address[15:8], data[7:0]}, valid one cycle after tbl_addr changes.
REQ-014 i2c_request  out  1  transaction request to the I2C master.
REQ-015 i2c_wr  out  1  direction to the master; tied high (write).
REQ-016 i2c_length  out  8  byte count to the master; constant 8'd1.
REQ-017 i2c_address  out  7  device address to the master; equals DEV_ADDR.
REQ-018 i2c_sub_address  out  8  latched tbl_data[15:8].
REQ-019 i2c_tx  out  8  latched tbl_data[7:0].
REQ-020 i2c_de  in  1  master byte-done strobe; SCL-domain, asynchronous to clk_50.
REQ-021 i2c_busy  in  1  master busy indication (its error output); asynchronous to clk_50.

Function
REQ-022 The block SHALL pass i2c_de and i2c_busy through two-flop synchronisers; all logic uses only the synchronised versions.
REQ-023 The FSM SHALL have states IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, GAP, DONE and FAIL.
REQ-024 IDLE/DONE/FAIL + start: clear done, fail, tbl_addr and de_count; go to DONE if NUM_REGS==0, otherwise to FETCH.
REQ-025 FETCH: wait one cycle for ROM latency, then go to LATCH.
REQ-026 LATCH: load i2c_sub_address and i2c_tx from tbl_data, then go to ISSUE.
REQ-027 ISSUE: hold i2c_request=1 and count cycles; on sync busy=1, drop i2c_request and go to WAIT_DONE; after START_TIMEOUT cycles without busy, go to FAIL.
REQ-028 WAIT_DONE: count rising edges of sync i2c_de into de_count (saturating at 3).
REQ-029 WAIT_DONE on sync busy 1->0: go to GAP if de_count==1, otherwise go to FAIL.
REQ-030 WAIT_DONE SHALL go to FAIL after DONE_TIMEOUT cycles.
REQ-031 GAP: wait GAP_CYCLES cycles, clear de_count, then go to DONE if tbl_addr==NUM_REGS-1, otherwise increment tbl_addr and go to FETCH.
REQ-032 busy SHALL be 1 in every state except IDLE, DONE and FAIL.
REQ-033 i2c_request SHALL be 1 only in ISSUE.
REQ-034 start while busy=1 SHALL be ignored.
REQ-035 A single 16-bit timer SHALL serve ISSUE, WAIT_DONE and GAP; it clears on every state entry.
REQ-036 i2c_sub_address and i2c_tx SHALL be stable from LATCH until the next LATCH.

Reset
REQ-037 reset_n low SHALL immediately force: state IDLE; busy, done, fail, i2c_request 0; tbl_addr, i2c_sub_address, i2c_tx 0; timer, de_count and synchronisers 0.
REQ-038 Reset mid-transaction SHALL drop i2c_request asynchronously; the block SHALL NOT resume the run after reset.

Verification
REQ-039 NUM_REGS=3, ROM {0x0F00,0x0A12,0x1E34}, master model with busy 600 cycles and one DE -> three requests with sub/tx 0F/00, 0A/12, 1E/34; then done=1, fail=0, busy=0.
REQ-040 Model never asserts busy -> fail=1 after 4096 ISSUE cycles; tbl_addr=0; i2c_request=0.
REQ-041 Model pulses DE twice on entry 1 -> fail=1 at busy fall; tbl_addr=1; no request for entry 2.
REQ-042 NUM_REGS=0 with start -> done=1 two cycles later; no i2c_request.
REQ-043 reset_n low during WAIT_DONE of entry 1 -> all outputs 0 at once; after release, no request without a new start.
REQ-044 start pulses during a run -> ignored; the run completes normally with done=1.

Source files
------------

// File: rtl/i2c_cfg_seq.sv
// Walks a register table and writes each {sub_address, data} pair to one I2C device
// through an external byte-oriented master, with start/done timeouts and a DE-count check.
module i2c_cfg_seq #(
    parameter logic [6:0]  DEV_ADDR      = 7'h1A,
    parameter int unsigned NUM_REGS      = 10,
    parameter int unsigned START_TIMEOUT = 4096,
    parameter int unsigned DONE_TIMEOUT  = 65535,
    parameter int unsigned GAP_CYCLES    = 256
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        i2c_request,
    output logic        i2c_wr,
    output logic [7:0]  i2c_length,
    output logic [6:0]  i2c_address,
    output logic [7:0]  i2c_sub_address,
    output logic [7:0]  i2c_tx,
    input  logic        i2c_de,
    input  logic        i2c_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_DONE, S_GAP, S_DONE, S_FAIL
    } state_t;

    localparam logic [15:0] START_LAST = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] DONE_LAST  = 16'(DONE_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  LAST_IDX   = 8'(NUM_REGS - 1);

    state_t      state;
    logic [15:0] timer;
    logic [1:0]  de_count;
    logic        de_s1, de_s2, de_prev;
    logic        bsy_s1, bsy_s2;
    logic        de_rise;
    logic [1:0]  de_next;

    assign i2c_wr      = 1'b1;
    assign i2c_length  = 8'd1;
    assign i2c_address = DEV_ADDR;

    // Include a DE edge landing in the same cycle as the busy fall in the final count.
    assign de_rise = de_s2 & ~de_prev;
    assign de_next = (de_rise && de_count != 2'd3) ? de_count + 2'd1 : de_count;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            fail            <= 1'b0;
            i2c_request     <= 1'b0;
            tbl_addr        <= '0;
            i2c_sub_address <= '0;
            i2c_tx          <= '0;
            timer           <= '0;
            de_count        <= '0;
            de_s1           <= 1'b0;
            de_s2           <= 1'b0;
            de_prev         <= 1'b0;
            bsy_s1          <= 1'b0;
            bsy_s2          <= 1'b0;
        end else begin
            de_s1   <= i2c_de;
            de_s2   <= de_s1;
            de_prev <= de_s2;
            bsy_s1  <= i2c_busy;
            bsy_s2  <= bsy_s1;
            timer   <= timer + 16'd1;

            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (state == S_DONE) done <= 1'b1;
                    if (state == S_FAIL) fail <= 1'b1;
                    if (start) begin
                        done     <= 1'b0;
                        fail     <= 1'b0;
                        tbl_addr <= '0;
                        de_count <= '0;
                        timer    <= '0;
                        if (NUM_REGS == 0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                    timer <= '0;
                end
                S_LATCH: begin
                    i2c_sub_address <= tbl_data[15:8];
                    i2c_tx          <= tbl_data[7:0];
                    i2c_request     <= 1'b1;
                    state           <= S_ISSUE;
                    timer           <= '0;
                end
                S_ISSUE: begin
                    if (bsy_s2) begin
                        i2c_request <= 1'b0;
                        state       <= S_WAIT_DONE;
                        timer       <= '0;
                    end else if (timer == START_LAST) begin
                        i2c_request <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_FAIL;
                        timer       <= '0;
                    end
                end
                S_WAIT_DONE: begin
                    de_count <= de_next;
                    if (!bsy_s2) begin
                        timer <= '0;
                        if (de_next == 2'd1) begin
                            state <= S_GAP;
                        end else begin
                            state <= S_FAIL;
                            busy  <= 1'b0;
                        end
                    end else if (timer == DONE_LAST) begin
                        state <= S_FAIL;
                        busy  <= 1'b0;
                        timer <= '0;
                    end
                end
                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer    <= '0;
                        de_count <= '0;
                        if (tbl_addr == LAST_IDX) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end else begin
                            tbl_addr <= tbl_addr + 8'd1;
                            state    <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed bench for i2c_cfg_seq: behavioural I2C master model plus a payload scoreboard.
module tb_i2c_cfg_seq;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        start, start0;
    logic        busy, done, fail;
    logic        busy0, done0, fail0;
    logic [7:0]  tbl_addr, tbl_addr0;
    logic [15:0] tbl_data;
    logic        i2c_request, i2c_wr, i2c_request0, i2c_wr0;
    logic [7:0]  i2c_length, i2c_sub_address, i2c_tx, i2c_length0, i2c_sub0, i2c_tx0;
    logic [6:0]  i2c_address, i2c_address0;
    logic        i2c_de, i2c_busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [3];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          tx_total  = 0;
    int          double_at = -1;
    logic        model_silent = 1'b0;
    int          req_rises = 0;
    int          req_high  = 0;
    logic        req_prev  = 1'b0;

    always #10 clk_50 = ~clk_50;

    i2c_cfg_seq #(.DEV_ADDR(7'h1A), .NUM_REGS(3), .START_TIMEOUT(4096),
                  .DONE_TIMEOUT(65535), .GAP_CYCLES(256)) dut (
        .clk_50(clk_50), .reset_n(reset_n), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .i2c_request(i2c_request), .i2c_wr(i2c_wr), .i2c_length(i2c_length),
        .i2c_address(i2c_address), .i2c_sub_address(i2c_sub_address), .i2c_tx(i2c_tx),
        .i2c_de(i2c_de), .i2c_busy(i2c_busy)
    );

    i2c_cfg_seq #(.NUM_REGS(0)) dut0 (
        .clk_50(clk_50), .reset_n(reset_n), .start(start0),
        .busy(busy0), .done(done0), .fail(fail0),
        .tbl_addr(tbl_addr0), .tbl_data(16'h0000),
        .i2c_request(i2c_request0), .i2c_wr(i2c_wr0), .i2c_length(i2c_length0),
        .i2c_address(i2c_address0), .i2c_sub_address(i2c_sub0), .i2c_tx(i2c_tx0),
        .i2c_de(1'b0), .i2c_busy(1'b0)
    );

    // Registered table ROM: one cycle of read latency.
    always @(posedge clk_50)
        tbl_data <= (tbl_addr < 8'd3) ? rom[tbl_addr] : 16'h0000;

    always @(negedge clk_50) begin
        if (i2c_request && !req_prev) req_rises <= req_rises + 1;
        if (i2c_request) req_high <= req_high + 1;
        req_prev <= i2c_request;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_50); #1; end
    endtask

    // Master model: busy for 600 cycles with one DE strobe, or two on the selected transaction.
    initial begin
        i2c_busy = 1'b0;
        i2c_de   = 1'b0;
        forever begin
            tick(1);
            if (i2c_request && !model_silent) begin
                got_q.push_back({i2c_sub_address, i2c_tx});
                tick(2);
                i2c_busy = 1'b1;
                tick(200);
                i2c_de = 1'b1; tick(4); i2c_de = 1'b0;
                if (tx_total == double_at) begin
                    tick(50);
                    i2c_de = 1'b1; tick(4); i2c_de = 1'b0;
                    tick(342);
                end else begin
                    tick(396);
                end
                i2c_busy = 1'b0;
                tx_total++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int n = 0;
        while (!(done || fail) && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_ended"}, 32'(done || fail), 32'd1);
    endtask

    task automatic push_entries(input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(rom[i]);
    endtask

    task automatic sb_drain(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() != 0 && exp_q.size() != 0)
            check({tag, "_payload"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    int base_rises, base_high, base_tx, n;

    initial begin
        rom[0] = 16'h0F00;
        rom[1] = 16'h0A12;
        rom[2] = 16'h1E34;
        reset_n = 1'b0;
        start   = 1'b0;
        start0  = 1'b0;
        tick(5);
        reset_n = 1'b1;
        tick(2);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_req", 32'(i2c_request), 32'd0);
        check("rst_addr", 32'(tbl_addr), 32'd0);
        check("rst_sub_tx", 32'({i2c_sub_address, i2c_tx}), 32'd0);
        check("const_wr", 32'(i2c_wr), 32'd1);
        check("const_len", 32'(i2c_length), 32'd1);
        check("const_dev", 32'(i2c_address), 32'h1A);

        // Zero-length table completes without touching the bus.
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        check("empty_done_c1", 32'(done0), 32'd0);
        tick(1);
        check("empty_done_c2", 32'(done0), 32'd1);
        check("empty_busy", 32'(busy0), 32'd0);
        check("empty_req", 32'(i2c_request0), 32'd0);

        // Full three-entry run.
        base_rises = req_rises;
        push_entries(3);
        pulse_start();
        check("run_busy", 32'(busy), 32'd1);
        wait_end(20000, "run");
        check("run_done", 32'(done), 32'd1);
        check("run_fail", 32'(fail), 32'd0);
        check("run_busy_end", 32'(busy), 32'd0);
        check("run_last_addr", 32'(tbl_addr), 32'd2);
        check("run_requests", 32'(req_rises - base_rises), 32'd3);
        sb_drain("run");

        // Starts during a run are ignored.
        base_rises = req_rises;
        push_entries(3);
        pulse_start();
        check("ign_done_clr", 32'(done), 32'd0);
        foreach (rom[i]) begin
            tick(700);
            check("ign_busy", 32'(busy), 32'd1);
            pulse_start();
        end
        wait_end(20000, "ign");
        check("ign_done", 32'(done), 32'd1);
        check("ign_fail", 32'(fail), 32'd0);
        check("ign_requests", 32'(req_rises - base_rises), 32'd3);
        sb_drain("ign");

        // Master never goes busy: start timeout.
        model_silent = 1'b1;
        base_rises = req_rises;
        base_high  = req_high;
        pulse_start();
        wait_end(6000, "nobusy");
        tick(2);
        check("nobusy_fail", 32'(fail), 32'd1);
        check("nobusy_done", 32'(done), 32'd0);
        check("nobusy_addr", 32'(tbl_addr), 32'd0);
        check("nobusy_req", 32'(i2c_request), 32'd0);
        check("nobusy_req_cycles", 32'(req_high - base_high), 32'd4096);
        check("nobusy_requests", 32'(req_rises - base_rises), 32'd1);
        model_silent = 1'b0;
        got_q.delete();

        // Two DE strobes on entry 1.
        base_rises = req_rises;
        double_at  = tx_total + 1;
        push_entries(2);
        pulse_start();
        wait_end(20000, "dblde");
        tick(2);
        check("dblde_fail", 32'(fail), 32'd1);
        check("dblde_done", 32'(done), 32'd0);
        check("dblde_addr", 32'(tbl_addr), 32'd1);
        check("dblde_requests", 32'(req_rises - base_rises), 32'd2);
        sb_drain("dblde");
        double_at = -1;
        tick(300);
        check("dblde_no_more", 32'(req_rises - base_rises), 32'd2);

        // Reset while waiting for entry 1 to finish.
        base_tx = tx_total;
        push_entries(2);
        pulse_start();
        n = 0;
        while (!(tx_total == base_tx + 1 && i2c_busy) && n < 3000) begin
            tick(1);
            n++;
        end
        check("rstmid_reached", 32'(tx_total == base_tx + 1 && i2c_busy), 32'd1);
        tick(300);
        check("rstmid_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_req", 32'(i2c_request), 32'd0);
        check("rstmid_addr", 32'(tbl_addr), 32'd0);
        check("rstmid_sub_tx", 32'({i2c_sub_address, i2c_tx}), 32'd0);
        check("rstmid_done_fail", 32'({done, fail}), 32'd0);
        tick(3);
        reset_n = 1'b1;
        base_rises = req_rises;
        tick(1500);
        check("rstmid_no_resume", 32'(req_rises - base_rises), 32'd0);
        check("rstmid_idle", 32'({busy, done, fail}), 32'd0);
        sb_drain("rstmid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
